// File: rtl/control_espirometro.sv
// Spirometer session controller: paces the external ADC, strobes the flow scaler
// and measures one expiration (baseline, breath detection, volume, peak, end).
module control_espirometro #(
    parameter int SAMPLE_DIV    = 5000,
    parameter int CONV_TIMEOUT  = 255,
    parameter int THRESH        = 8,
    parameter int QUIET_SAMPLES = 50,
    parameter int MAX_SAMPLES   = 4095
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic        iAbort,
    output logic        oADC_Start,
    input  logic        iADC_Done,
    input  logic [7:0]  ivADC_Dato,
    output logic [7:0]  ovDatos,
    output logic        oCE,
    input  logic [9:0]  ivFlujo,
    output logic [9:0]  ovPico,
    output logic [19:0] ovVolumen,
    output logic [11:0] ovMuestras,
    output logic        oBusy,
    output logic        oListo,
    output logic        oError
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(CONV_TIMEOUT + 1);
    localparam int QW = $clog2(QUIET_SAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_CONV      = 3'd2,
        S_STROBE    = 3'd3,
        S_PROC      = 3'd4,
        S_DONE      = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        P_BASE  = 2'd0,
        P_ARMED = 2'd1,
        P_MEAS  = 2'd2
    } phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic [TW-1:0]   r_tick_cnt;
    logic [CW-1:0]   r_conv_cnt;
    logic [12:0]     r_base_sum;
    logic [2:0]      r_base_cnt;
    logic [QW-1:0]   r_quiet;
    logic            r_proc_wait;

    logic            w_tick;
    logic [9:0]      w_base;
    logic [9:0]      w_delta;
    logic [9:0]      w_pico_next;
    logic [20:0]     w_vol_sum;
    logic [19:0]     w_vol_next;
    logic [11:0]     w_muestras_next;
    logic [QW-1:0]   w_quiet_next;
    logic            w_fin;

    // Per-sample arithmetic on the scaled flow: delta over baseline and next results.
    always_comb begin
        w_tick = (r_tick_cnt == TW'(SAMPLE_DIV - 1));
        w_base = r_base_sum[12:3];
        if (ivFlujo > w_base) begin
            w_delta = ivFlujo - w_base;
        end else begin
            w_delta = 10'd0;
        end
        w_vol_sum = {1'b0, ovVolumen} + {11'd0, w_delta};
        if (w_vol_sum[20]) begin
            w_vol_next = 20'hFFFFF;
        end else begin
            w_vol_next = w_vol_sum[19:0];
        end
        if (w_delta > ovPico) begin
            w_pico_next = w_delta;
        end else begin
            w_pico_next = ovPico;
        end
        if (w_delta < 10'(THRESH)) begin
            w_quiet_next = r_quiet + QW'(1);
        end else begin
            w_quiet_next = {QW{1'b0}};
        end
        w_muestras_next = ovMuestras + 12'd1;
        w_fin = (w_quiet_next == QW'(QUIET_SAMPLES)) || (w_muestras_next == 12'(MAX_SAMPLES));
    end

    // Session FSM with registered pulses, sample pacing and result accumulation.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state     <= S_IDLE;
            r_phase     <= P_BASE;
            r_tick_cnt  <= {TW{1'b0}};
            r_conv_cnt  <= {CW{1'b0}};
            r_base_sum  <= 13'd0;
            r_base_cnt  <= 3'd0;
            r_quiet     <= {QW{1'b0}};
            r_proc_wait <= 1'b0;
            oADC_Start  <= 1'b0;
            ovDatos     <= 8'd0;
            oCE         <= 1'b0;
            ovPico      <= 10'd0;
            ovVolumen   <= 20'd0;
            ovMuestras  <= 12'd0;
            oBusy       <= 1'b0;
            oListo      <= 1'b0;
            oError      <= 1'b0;
        end else if (iAbort) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= {TW{1'b0}};
            oBusy      <= 1'b0;
            oCE        <= 1'b0;
            oADC_Start <= 1'b0;
        end else begin
            oADC_Start <= 1'b0;
            oCE        <= 1'b0;
            if (oBusy) begin
                r_tick_cnt <= w_tick ? {TW{1'b0}} : r_tick_cnt + TW'(1);
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (iStart) begin
                        r_state    <= S_WAIT_TICK;
                        r_phase    <= P_BASE;
                        r_tick_cnt <= {TW{1'b0}};
                        r_base_sum <= 13'd0;
                        r_base_cnt <= 3'd0;
                        r_quiet    <= {QW{1'b0}};
                        ovPico     <= 10'd0;
                        ovVolumen  <= 20'd0;
                        ovMuestras <= 12'd0;
                        oListo     <= 1'b0;
                        oError     <= 1'b0;
                        oBusy      <= 1'b1;
                    end
                end
                S_WAIT_TICK: begin
                    if (w_tick) begin
                        r_state    <= S_CONV;
                        r_conv_cnt <= {CW{1'b0}};
                        oADC_Start <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (iADC_Done) begin
                        ovDatos <= ivADC_Dato;
                        oCE     <= 1'b1;
                        r_state <= S_STROBE;
                    end else if (r_conv_cnt == CW'(CONV_TIMEOUT - 1)) begin
                        r_state <= S_ERROR;
                        oError  <= 1'b1;
                        oBusy   <= 1'b0;
                    end else begin
                        r_conv_cnt <= r_conv_cnt + CW'(1);
                    end
                end
                S_STROBE: begin
                    r_state     <= S_PROC;
                    r_proc_wait <= 1'b1;
                end
                S_PROC: begin
                    // The scaler registers on oCE; one spare cycle before ivFlujo is read.
                    if (r_proc_wait) begin
                        r_proc_wait <= 1'b0;
                    end else begin
                        r_state <= S_WAIT_TICK;
                        case (r_phase)
                            P_BASE: begin
                                r_base_sum <= r_base_sum + {3'd0, ivFlujo};
                                r_base_cnt <= r_base_cnt + 3'd1;
                                if (r_base_cnt == 3'd7) begin
                                    r_phase <= P_ARMED;
                                end
                            end
                            P_ARMED, P_MEAS: begin
                                if ((r_phase == P_MEAS) || (w_delta >= 10'(THRESH))) begin
                                    r_phase    <= P_MEAS;
                                    ovMuestras <= w_muestras_next;
                                    ovVolumen  <= w_vol_next;
                                    ovPico     <= w_pico_next;
                                    r_quiet    <= w_quiet_next;
                                    if (w_fin) begin
                                        r_state <= S_DONE;
                                        oListo  <= 1'b1;
                                        oBusy   <= 1'b0;
                                    end
                                end
                            end
                            default: begin
                                r_phase <= P_BASE;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/control_espirometro.md
# control_espirometro

Session controller for the spirometer ADC path. Paces conversions of the external 8-bit ADC and hands each sample to the flow-scaling stage with a one-cycle clock-enable. It reads back the 10-bit scaled flow and runs one expiration measurement: baseline, breath detection, volume/peak accumulation and end-of-breath detection. Sits between the ADC pins and the flow scaler; its results feed the Bluetooth/Android reporting logic.

## Interface
- SAMPLE_DIV, 5000: clock cycles per sample period; must exceed CONV_TIMEOUT+4.
- CONV_TIMEOUT, 255: maximum cycles from oADC_Start to iADC_Done.
- THRESH, 8: flow units above baseline that count as breath.
- QUIET_SAMPLES, 50: consecutive sub-threshold samples that end the breath.
- MAX_SAMPLES, 4095: measured-sample limit.
- iClk  in  1  system clock, all logic on rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iStart  in  1  pulse; begins a session when not busy.
- iAbort  in  1  level; forces IDLE.
- oADC_Start  out  1  one-cycle start-of-conversion pulse.
- iADC_Done  in  1  end-of-conversion, high while data valid.
- ivADC_Dato  in  8  ADC data.
- ovDatos  out  8  latched sample to the scaler.
- oCE  out  1  one-cycle enable to the scaler.
- ivFlujo  in  10  registered scaler output; valid the cycle after oCE.
- ovPico  out  10  peak flow above baseline.
- ovVolumen  out  20  sum of flow above baseline, saturating.
- ovMuestras  out  12  samples counted in the measured phase.
- oBusy  out  1  session running.
- oListo  out  1  results valid, held until the next start.
- oError  out  1  ADC timeout, held until the next start.

## Operation
- Reset: every output is 0 and the FSM is in IDLE.
- Main FSM: IDLE → WAIT_TICK → CONV → STROBE → PROC → WAIT_TICK …, with exits to DONE and ERROR.
- Phase register: BASE → ARMED → MEAS.
- iStart in IDLE, DONE or ERROR:
  - clears all results, oListo and oError;
  - sets phase BASE and oBusy;
  - zeroes the tick counter;
  - enters WAIT_TICK.
- iStart while busy is ignored.
- Tick counter counts 0..SAMPLE_DIV-1 while busy and wraps. The tick is acted on only in WAIT_TICK.
- CONV: oADC_Start is high on the first CONV cycle only, then the block waits for iADC_Done.
  - iADC_Done seen: ovDatos←ivADC_Dato, go to STROBE.
  - CONV_TIMEOUT cycles without iADC_Done: go to ERROR.
- STROBE: oCE=1 for exactly one cycle, then PROC.
- PROC reads ivFlujo and returns to WAIT_TICK unless an exit fires.
- Baseline: the first 8 samples are summed into a 13-bit register; base = sum>>3.
  - The 8th sample moves the phase to ARMED; baseline samples are not measured.
- Flow above baseline: delta = ivFlujo>base ? ivFlujo−base : 0, 10 bits.
- ARMED: delta≥THRESH moves to MEAS, and this sample is processed as the first MEAS sample.
- MEAS, per sample:
  - ovMuestras+1;
  - ovVolumen+=delta, saturating at 0xFFFFF;
  - ovPico=max(ovPico, delta);
  - quiet counter increments when delta<THRESH, otherwise clears.
- DONE when quiet==QUIET_SAMPLES or ovMuestras==MAX_SAMPLES: oListo=1, oBusy=0.
- ERROR: oError=1, oBusy=0, partial results held.
- iAbort has priority over everything, including a simultaneous iStart.
  - Next state is IDLE; oBusy, oCE and oADC_Start go to 0 next cycle.
  - Results are held and oListo stays 0.
- Asynchronous reset mid-conversion returns to the reset state immediately; a late iADC_Done is ignored.

## Timing
- iStart sampled at edge k: oBusy=1 from k+1; the first tick comes SAMPLE_DIV cycles later.
- Tick to oADC_Start: 1 cycle.
- iADC_Done sampled at edge d:
  - ovDatos valid from d+1;
  - oCE high in cycle d+1;
  - ivFlujo captured at edge d+3.
- Results update at edge d+3.
- oListo/oError rise at the same edge the last PROC or timeout resolves.
- Exactly one oCE per sample period; no oCE when the ADC times out.

## Test plan
- ADC model answering after 10 cycles with 5 (flow 20) for 8 samples, then 15 (flow 60) for 20 samples, then 5 → base=20, delta=40 per measured sample; DONE after 20+50 measured samples. Required: ovMuestras=70, ovVolumen=800, ovPico=40, oListo=1.
- ADC never asserts iADC_Done → oError=1 exactly 255 cycles after oADC_Start; oBusy=0; no oCE pulse.
- iAbort mid-MEAS → IDLE next cycle, oBusy=0, results held, oListo=0. iStart together with iAbort → stays IDLE.
- Constant flow 1020 with base 0 → ovVolumen saturates at 0xFFFFF. DONE at ovMuestras=4095.
- Reset asserted during CONV → all outputs 0 immediately; a following iStart runs a clean session.
- Period check: with SAMPLE_DIV=5000, oCE pulses are exactly 5000 cycles apart. iStart while busy has no effect.
